encoder_8x3: RTL and testbench
==============================

// Module: encoder_8x3
// PURPOSE
//   Registered 8-to-3 binary encoder. Converts an 8-bit one-hot input into the
//   3-bit index of its set bit, with valid and error flags. Sits between
//   one-hot request or select sources and binary-indexed consumers such as
//   mux selects and address fields.
// PARAMETERS
//   PRIORITY_HIGH  1  multi-hot resolution: 1 = highest set bit wins, 0 = lowest set bit wins
// PORTS
//   clk    in   1  rising-edge clock; the only clock
//   rst_n  in   1  reset, synchronous, active-low
//   en     in   1  sample enable; outputs update only when en=1
//   data   in   8  one-hot input; bit i set means index i
//   code   out  3  encoded index of the set bit in data
//   valid  out  1  1 = data had at least one bit set
//   err    out  1  1 = data was not exactly one-hot (zero bits, several bits, or X/Z)
// BEHAVIOUR
//   - One clock, rising edge. Reset is synchronous and active-low (rst_n).
//   - Reset: on a clk edge with rst_n=0, code=3'd0, valid=0, err=0. Reset wins over en.
//   - Latency: 1 cycle. Outputs reflect the data sampled at the last edge with en=1.
//   - en=0: code, valid and err hold their previous values.
//   - One-hot data, bit i set: code=i, valid=1, err=0.
//     Mapping: 8'h01->0, 8'h02->1, 8'h04->2, 8'h08->3, 8'h10->4, 8'h20->5, 8'h40->6, 8'h80->7.
//   - data=8'h00: code=0, valid=0, err=1.
//   - Multi-hot data: valid=1, err=1.
//     PRIORITY_HIGH=1: code = index of the highest set bit.
//     PRIORITY_HIGH=0: code = index of the lowest set bit.
//   - X/Z on any data bit (simulation only): code=0, valid=0, err=1.
//     Implement with an exhaustive one-hot case statement plus a default branch,
//     so no X propagates to the outputs. Synthesis covers this via the default branch.
//   - Purely combinational decode feeds the output registers. There is no other
//     state and no handshake.
//   - Reset asserted mid-stream clears the outputs on that edge. The first en=1
//     edge after rst_n returns high captures fresh data.
// TESTING
//   1. Reset: rst_n=0 for 2 edges with data=8'h80, en=1 -> code=0, valid=0, err=0.
//   2. Walking one: en=1, data=8'h01 shifted left once per cycle through 8'h80
//      -> one cycle later code=0,1,...,7 in turn, valid=1, err=0 on every cycle.
//   3. Zero and X: data=8'h00 -> code=0, valid=0, err=1.
//      data=8'hxx -> code=0, valid=0, err=1, with no X on any output.
//   4. Multi-hot: data=8'h24 -> PRIORITY_HIGH=1 gives code=5; PRIORITY_HIGH=0 gives code=2.
//      valid=1 and err=1 in both cases.
//   5. Hold: capture data=8'h10 (code=4), then set en=0 and data=8'h02 for 3 cycles
//      -> code stays 4.
//   6. Mid-stream reset: during the walking-one sequence, drive rst_n=0 for one edge
//      -> outputs are all 0 after that edge. Next edge with rst_n=1 and data=8'h40 -> code=6.

Source files
------------

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 one-hot encoder with valid/err flags.
// Multi-hot inputs resolve to the highest or lowest set bit, selected by PRIORITY_HIGH.
module encoder_8x3 #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] data,
  output logic [2:0] code,
  output logic       valid,
  output logic       err
);

  // Returns {found, index} of the highest set bit.
  function automatic logic [3:0] pick_high(input logic [7:0] d);
    logic [3:0] r;
    casez (d)
      8'b1???????: r = 4'b1_111;
      8'b01??????: r = 4'b1_110;
      8'b001?????: r = 4'b1_101;
      8'b0001????: r = 4'b1_100;
      8'b00001???: r = 4'b1_011;
      8'b000001??: r = 4'b1_010;
      8'b0000001?: r = 4'b1_001;
      8'b00000001: r = 4'b1_000;
      default:     r = 4'b0_000;
    endcase
    return r;
  endfunction

  // Returns {found, index} of the lowest set bit.
  function automatic logic [3:0] pick_low(input logic [7:0] d);
    logic [3:0] r;
    casez (d)
      8'b???????1: r = 4'b1_000;
      8'b??????10: r = 4'b1_001;
      8'b?????100: r = 4'b1_010;
      8'b????1000: r = 4'b1_011;
      8'b???10000: r = 4'b1_100;
      8'b??100000: r = 4'b1_101;
      8'b?1000000: r = 4'b1_110;
      8'b10000000: r = 4'b1_111;
      default:     r = 4'b0_000;
    endcase
    return r;
  endfunction

  logic [2:0] w_code;
  logic       w_valid;
  logic       w_err;
  logic [3:0] w_pick;

  logic [2:0] r_code;
  logic       r_valid;
  logic       r_err;

  // Exact one-hot matches first; anything else (multi-hot, or unknown bits that
  // match no pattern) falls to the default branch and never propagates X.
  always_comb begin
    w_code  = 3'd0;
    w_valid = 1'b0;
    w_err   = 1'b1;
    w_pick  = 4'b0_000;
    case (data)
      8'h01: begin w_code = 3'd0; w_valid = 1'b1; w_err = 1'b0; end
      8'h02: begin w_code = 3'd1; w_valid = 1'b1; w_err = 1'b0; end
      8'h04: begin w_code = 3'd2; w_valid = 1'b1; w_err = 1'b0; end
      8'h08: begin w_code = 3'd3; w_valid = 1'b1; w_err = 1'b0; end
      8'h10: begin w_code = 3'd4; w_valid = 1'b1; w_err = 1'b0; end
      8'h20: begin w_code = 3'd5; w_valid = 1'b1; w_err = 1'b0; end
      8'h40: begin w_code = 3'd6; w_valid = 1'b1; w_err = 1'b0; end
      8'h80: begin w_code = 3'd7; w_valid = 1'b1; w_err = 1'b0; end
      8'h00: begin w_code = 3'd0; w_valid = 1'b0; w_err = 1'b1; end
      default: begin
        if (PRIORITY_HIGH) begin
          w_pick = pick_high(data);
        end else begin
          w_pick = pick_low(data);
        end
        w_code  = w_pick[2:0];
        w_valid = w_pick[3];
        w_err   = 1'b1;
      end
    endcase
  end

  // Output registers: reset has priority over en; en=0 holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_code  <= 3'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_code  <= w_code;
      r_valid <= w_valid;
      r_err   <= w_err;
    end else begin
      r_code  <= r_code;
      r_valid <= r_valid;
      r_err   <= r_err;
    end
  end

  assign code  = r_code;
  assign valid = r_valid;
  assign err   = r_err;

endmodule

// File: tb/tb_encoder_8x3.sv
// Scoreboard bench for encoder_8x3: both priority variants driven in parallel,
// expected responses queued at stimulus time and checked by a negedge monitor.
module tb_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] data;
  logic [2:0] code_hi, code_lo;
  logic       valid_hi, valid_lo;
  logic       err_hi, err_lo;

  typedef struct packed {
    logic [2:0] code_hi;
    logic [2:0] code_lo;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  encoder_8x3 #(.PRIORITY_HIGH(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .code(code_hi), .valid(valid_hi), .err(err_hi)
  );

  encoder_8x3 #(.PRIORITY_HIGH(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data),
    .code(code_lo), .valid(valid_lo), .err(err_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every negedge after a driven edge, compare against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("code_hi",  code_hi,          e.code_hi);
      check("valid_hi", {2'b00, valid_hi}, {2'b00, e.valid});
      check("err_hi",   {2'b00, err_hi},   {2'b00, e.err});
      check("code_lo",  code_lo,          e.code_lo);
      check("valid_lo", {2'b00, valid_lo}, {2'b00, e.valid});
      check("err_lo",   {2'b00, err_lo},   {2'b00, e.err});
    end
  end

  // Drive one edge worth of inputs and queue the outputs expected after that edge.
  task automatic tick(input logic r, input logic e, input logic [7:0] d,
                      input logic [2:0] ch, input logic [2:0] cl,
                      input logic v, input logic er);
    exp_t x;
    rst_n = r;
    en    = e;
    data  = d;
    x.code_hi = ch;
    x.code_lo = cl;
    x.valid   = v;
    x.err     = er;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] xdata;
    rst_n = 1'b0;
    en    = 1'b0;
    data  = 8'h00;
    xdata = 8'hxx;

    // Reset with en=1 and a one-hot input present
    tick(1'b0, 1'b1, 8'h80, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 8'h80, 3'd0, 3'd0, 1'b0, 1'b0);

    // Walking one
    tick(1'b1, 1'b1, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h02, 3'd1, 3'd1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h04, 3'd2, 3'd2, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h08, 3'd3, 3'd3, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h10, 3'd4, 3'd4, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h20, 3'd5, 3'd5, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h40, 3'd6, 3'd6, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h80, 3'd7, 3'd7, 1'b1, 1'b0);

    // Zero and unknown input
    tick(1'b1, 1'b1, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, xdata, 3'd0, 3'd0, 1'b0, 1'b1);

    // Multi-hot
    tick(1'b1, 1'b1, 8'h24, 3'd5, 3'd2, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 8'h81, 3'd7, 3'd0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 8'hFF, 3'd7, 3'd0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 8'h0C, 3'd3, 3'd2, 1'b1, 1'b1);

    // Hold with en=0
    tick(1'b1, 1'b1, 8'h10, 3'd4, 3'd4, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 8'h02, 3'd4, 3'd4, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 8'h02, 3'd4, 3'd4, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 8'h02, 3'd4, 3'd4, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 3'd4, 3'd4, 1'b1, 1'b0);

    // Mid-stream reset during a walk, then fresh capture
    tick(1'b1, 1'b1, 8'h01, 3'd0, 3'd0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h02, 3'd1, 3'd1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 8'h04, 3'd2, 3'd2, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 8'h08, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 8'h40, 3'd6, 3'd6, 1'b1, 1'b0);

    // Reset wins even with en=0, then outputs hold at the reset value
    tick(1'b0, 1'b0, 8'h20, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h20, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 8'h20, 3'd5, 3'd5, 1'b1, 1'b0);

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
